// File: rtl/if_id_stage.sv
// IF stage with an IF/ID pipeline register. Fetches one word at a time from an
// acknowledged instruction memory, honouring stall and branch-redirect requests.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCwrite,
  input  logic        IF_IDwrite,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {StFetch, StHold, StDiscard} state_e;

  state_e      state_q, state_d;
  logic        started_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] old_addr_q, old_addr_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] stall_q, stall_d;

  // The first cycle after reset release is idle so a stale ack cannot be taken.
  assign imem_req    = started_q && (state_q != StHold);
  assign imem_addr   = (state_q == StDiscard) ? old_addr_q : pc_q;
  assign if_id_pc    = ifid_pc_q;
  assign if_id_instr = ifid_instr_q;
  assign if_id_valid = ifid_valid_q;
  assign stall_count = stall_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    old_addr_d   = old_addr_q;
    hold_d       = hold_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    stall_d      = stall_q;

    if (!IF_IDwrite && !branch_taken && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end

    if (started_q) begin
      if (branch_taken) begin
        pc_d         = branch_target;
        ifid_pc_d    = branch_target;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
        unique case (state_q)
          StFetch: begin
            // Request still in flight: keep presenting the old address until it completes.
            if (!imem_ack) begin
              state_d    = StDiscard;
              old_addr_d = pc_q;
            end
          end
          StHold:    state_d = StFetch;
          StDiscard: if (imem_ack) state_d = StFetch;
          default:   state_d = StFetch;
        endcase
      end else begin
        unique case (state_q)
          StFetch: begin
            if (imem_ack) begin
              if (IF_IDwrite) begin
                ifid_pc_d    = pc_q;
                ifid_instr_d = imem_rdata;
                ifid_valid_d = 1'b1;
                if (PCwrite) pc_d = pc_q + 32'd4;
              end else begin
                hold_d  = imem_rdata;
                state_d = StHold;
              end
            end else if (IF_IDwrite) begin
              ifid_pc_d    = pc_q;
              ifid_instr_d = NOP_INSTR;
              ifid_valid_d = 1'b0;
            end
          end
          StHold: begin
            if (IF_IDwrite) begin
              ifid_pc_d    = pc_q;
              ifid_instr_d = hold_q;
              ifid_valid_d = 1'b1;
              if (PCwrite) pc_d = pc_q + 32'd4;
              state_d = StFetch;
            end
          end
          StDiscard: if (imem_ack) state_d = StFetch;
          default:   state_d = StFetch;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      started_q    <= 1'b0;
      pc_q         <= RESET_PC;
      old_addr_q   <= RESET_PC;
      hold_q       <= 32'h0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      stall_q      <= 16'h0;
    end else begin
      state_q      <= state_d;
      started_q    <= 1'b1;
      pc_q         <= pc_d;
      old_addr_q   <= old_addr_d;
      hold_q       <= hold_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      stall_q      <= stall_d;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios plus random traffic, all checked
// against a transaction-level model of the fetch stage.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCwrite = 1'b0;
  logic        IF_IDwrite = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [15:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  if_id_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PCwrite      (PCwrite),
    .IF_IDwrite   (IF_IDwrite),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  // Model: a queue of fetched-but-not-delivered words, plus a flag for an
  // in-flight request whose answer must be thrown away.
  bit          m_started;
  logic [31:0] m_pc;
  logic [31:0] m_held[$];
  bit          m_flush;
  logic [31:0] m_flush_addr;
  logic [31:0] m_ifid_pc, m_ifid_instr;
  logic        m_ifid_valid;
  int          m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_req();
    return m_started && (m_held.size() == 0);
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_flush ? m_flush_addr : m_pc;
  endfunction

  task automatic model_reset();
    m_started = 0; m_pc = 32'h0; m_held.delete(); m_flush = 0; m_flush_addr = 32'h0;
    m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_ifid_valid = 1'b0; m_stall = 0;
  endtask

  task automatic model_step(input logic ifw, pcw, br, input logic [31:0] tgt,
                            input logic ack, input logic [31:0] rd);
    if (!ifw && !br && m_stall < 65535) m_stall++;
    if (!m_started) begin
      m_started = 1;
    end else if (br) begin
      if (m_flush) begin
        if (ack) m_flush = 0;
      end else if (m_held.size() != 0) begin
        m_held.delete();
      end else if (!ack) begin
        m_flush = 1;
        m_flush_addr = m_pc;
      end
      m_pc = tgt;
      m_ifid_pc = tgt; m_ifid_instr = NOP; m_ifid_valid = 1'b0;
    end else if (m_flush) begin
      if (ack) m_flush = 0;
    end else if (m_held.size() != 0) begin
      if (ifw) begin
        m_ifid_pc = m_pc; m_ifid_instr = m_held.pop_front(); m_ifid_valid = 1'b1;
        if (pcw) m_pc = m_pc + 32'd4;
      end
    end else if (ack) begin
      if (ifw) begin
        m_ifid_pc = m_pc; m_ifid_instr = rd; m_ifid_valid = 1'b1;
        if (pcw) m_pc = m_pc + 32'd4;
      end else begin
        m_held.push_back(rd);
      end
    end else if (ifw) begin
      m_ifid_pc = m_pc; m_ifid_instr = NOP; m_ifid_valid = 1'b0;
    end
  endtask

  task automatic chk_regs();
    chk("if_id_pc", if_id_pc, m_ifid_pc);
    chk("if_id_instr", if_id_instr, m_ifid_instr);
    chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_ifid_valid});
    chk("stall_count", {16'h0, stall_count}, m_stall[31:0]);
  endtask

  // Starts just after a rising edge; ends 1ns after the next one.
  task automatic cycle(input logic ifw, pcw, br, input logic [31:0] tgt,
                       input logic ack, input logic [31:0] rd);
    IF_IDwrite = ifw; PCwrite = pcw; branch_taken = br; branch_target = tgt;
    imem_ack = ack; imem_rdata = rd;
    #1;
    chk("imem_req", {31'h0, imem_req}, {31'h0, exp_req()});
    chk("imem_addr", imem_addr, exp_addr());
    @(posedge clk);
    model_step(ifw, pcw, br, tgt, ack, rd);
    #1;
    chk_regs();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk_regs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Stale ack in the first cycle after release must be ignored.
    cycle(1, 1, 0, 0, 1, 32'hDEAD_BEEF);
    chk("idle_after_reset_valid", {31'h0, if_id_valid}, 32'h0);
    cycle(1, 1, 0, 0, 1, word(32'h0));
    chk("stream_pc0", if_id_pc, 32'h0);
    cycle(1, 1, 0, 0, 1, word(32'h4));
    chk("stream_pc4", if_id_pc, 32'h4);

    // Load-use stall while the word for pc 8 comes back.
    cycle(0, 0, 0, 0, 1, word(32'h8));
    chk("stall_holds_pc4", if_id_pc, 32'h4);
    cycle(1, 1, 0, 0, 0, 32'h0);
    chk("hold_release_pc8", if_id_pc, 32'h8);
    chk("hold_release_data", if_id_instr, word(32'h8));
    chk("stall_count_one", {16'h0, stall_count}, 32'h1);
    cycle(1, 1, 0, 0, 1, word(32'hC));

    // Branch while the request for 0x10 is still waiting.
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 32'h100, 0, 0);
    chk("branch_valid0", {31'h0, if_id_valid}, 32'h0);
    chk("discard_old_addr", imem_addr, 32'h10);
    cycle(1, 1, 0, 0, 1, 32'hBAD0_BAD0);
    chk("redirect_addr", imem_addr, 32'h100);
    chk("dropped_word_valid", {31'h0, if_id_valid}, 32'h0);

    // PC wrap at the top of the address space.
    cycle(1, 1, 1, 32'hFFFF_FFFC, 1, 32'h1234_5678);
    cycle(1, 1, 0, 0, 1, word(32'hFFFF_FFFC));
    chk("wrap_last_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic ifw, pcw, br, ack;
      ifw = ($urandom_range(0, 3) != 0);
      pcw = ifw ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0);
      ack = exp_req() && ($urandom_range(0, 1) == 1);
      cycle(ifw, pcw, br, $urandom & 32'hFFFF_FFFC, ack, $urandom);
    end

    // Async reset mid-stream, then restart.
    do_reset();
    cycle(1, 1, 0, 0, 1, 32'hDEAD_BEEF);
    cycle(1, 1, 0, 0, 1, word(32'h0));
    chk("restart_pc0", if_id_pc, 32'h0);
    chk("restart_valid", {31'h0, if_id_valid}, 32'h1);

    // Saturating stall counter.
    for (int i = 0; i < 70000; i++) cycle(0, 0, 0, 0, 0, 0);
    chk("stall_saturated", {16'h0, stall_count}, 32'h0000_FFFF);
    cycle(0, 0, 0, 0, 0, 0);
    chk("stall_sat_holds", {16'h0, stall_count}, 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), the bubble instruction.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port PCwrite  input  1  hazard unit: 1 allows the PC to advance; 0 freezes the PC.
REQ-006 SHALL have port IF_IDwrite  input  1  hazard unit: 1 allows the IF/ID register to load; 0 holds it.
REQ-007 SHALL have port branch_taken  input  1  EX-stage redirect request, one-cycle pulse.
REQ-008 SHALL have port branch_target  input  32  redirect address, valid with branch_taken.
REQ-009 SHALL have port imem_req  output  1  instruction-memory request.
REQ-010 SHALL have port imem_addr  output  32  fetch address, stable while imem_req=1 and imem_ack=0.
REQ-011 SHALL have port imem_ack  input  1  memory response valid; completes the outstanding request.
REQ-012 SHALL have port imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-013 SHALL have port if_id_pc  output  32  PC of the instruction in IF/ID.
REQ-014 SHALL have port if_id_instr  output  32  instruction in IF/ID.
REQ-015 SHALL have port if_id_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
REQ-016 SHALL have port stall_count  output  16  number of cycles with IF_IDwrite=0, saturating.

Function
REQ-017 SHALL implement the states FETCH, HOLD and DISCARD, with at most one imem request outstanding.
REQ-018 In FETCH: imem_req=1 and imem_addr=pc.
REQ-019 FETCH, imem_ack=1, IF_IDwrite=1, no branch: load IF/ID with {pc, imem_rdata, valid=1}; pc<=pc+4 if PCwrite=1; remain in FETCH.
REQ-020 FETCH, imem_ack=1, IF_IDwrite=0, no branch: capture imem_rdata into a hold buffer; IF/ID unchanged; PC unchanged; go to HOLD.
REQ-021 FETCH, imem_ack=0, IF_IDwrite=1: load IF/ID with {pc, NOP_INSTR, valid=0}.
REQ-022 FETCH, imem_ack=0, IF_IDwrite=0: IF/ID unchanged.
REQ-023 In HOLD: imem_req=0.
REQ-024 HOLD, IF_IDwrite=1: load IF/ID from the hold buffer with valid=1; pc<=pc+4 if PCwrite=1; go to FETCH.
REQ-025 HOLD, IF_IDwrite=0: remain in HOLD.
REQ-026 branch_taken=1 SHALL override IF_IDwrite and PCwrite in every state: IF/ID<= {branch_target, NOP_INSTR, valid=0}; pc<=branch_target.
REQ-027 branch_taken in FETCH with imem_ack=0: go to DISCARD, keeping imem_req=1 and imem_addr at the old address until ack.
REQ-028 In DISCARD: on imem_ack, drop imem_rdata and go to FETCH at the redirected pc; imem_req=1 throughout.
REQ-029 branch_taken in FETCH with imem_ack=1, or in HOLD: drop the returned or held word and go to FETCH.
REQ-030 A second branch_taken in DISCARD SHALL overwrite pc with the new branch_target and remain in DISCARD.
REQ-031 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-032 stall_count SHALL increment on every cycle with IF_IDwrite=0 and branch_taken=0, and SHALL hold at 16'hFFFF.
REQ-033 Latency: an ack in FETCH with IF_IDwrite=1 SHALL appear on if_id_* on the next rising edge.

Reset
REQ-034 rst_n=0 SHALL immediately force: state FETCH; pc=RESET_PC; if_id_pc=0; if_id_instr=NOP_INSTR; if_id_valid=0; stall_count=0; hold buffer=0.
REQ-035 During reset SHALL force imem_req=0; imem_addr=RESET_PC.
REQ-036 Reset mid-request SHALL abandon the outstanding request; an ack in the first cycle after release SHALL be ignored.
REQ-037 Fetching SHALL begin with imem_req=1 on the second rising edge after rst_n deasserts.

Verification
REQ-038 Zero-wait stream: ack every cycle, IF_IDwrite=PCwrite=1 from reset -> if_id_pc = 0, 4, 8, 12 on consecutive cycles, valid=1.
REQ-039 Load-use stall: IF_IDwrite=PCwrite=0 for 1 cycle while ack arrives for pc=8 -> HOLD, IF/ID still pc=4; next cycle if_id_pc=8 with correct data; stall_count=1.
REQ-040 Branch with pending request: pc=0x10 request, ack delayed 3 cycles, branch_taken to 0x100 -> old data dropped, if_id_valid=0, next imem_addr=0x100.
REQ-041 Saturation: IF_IDwrite=0 for 70000 cycles -> stall_count=16'hFFFF and holds there.
REQ-042 Async reset: assert rst_n=0 mid-stream between clock edges -> outputs take reset values before the next edge; restart fetch at RESET_PC.
